// File: rtl/decode_pkg.sv
// Shared types for the decode queue stage: decoded bundle, queue entry and RV32 opcodes.
package decode_pkg;
  localparam int ADDR_W = 32;
  localparam int ILEN   = 32;
  localparam int REG_W  = 5;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    logic              is_alu;
    logic              is_load;
    logic              is_store;
    logic              is_branch;
    logic              is_jump;
    logic              is_jump_register;
    logic              opcode_legal;
    logic [ILEN-1:0]   immediate;
    logic              immediate_valid;
    logic [REG_W-1:0]  write_register;
    logic              writeback;
    logic [2:0]        funct3;
    logic              funct3_valid;
    logic [6:0]        funct7;
    logic              funct7_valid;
    logic [ADDR_W-1:0] pc;
    logic              target_misaligned;
  } decoded_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic              pc_valid;
    logic [ILEN-1:0]   instruction;
    logic              instruction_valid;
  } queue_entry_t;
endpackage

// File: rtl/branching.sv
// Branch condition evaluation from funct3 and the two resolved operands.
module branching #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] operand_1,
  input  logic [DATA_WIDTH-1:0] operand_2,
  output logic                  branch_condition
);
  always_comb begin
    branch_condition = 1'b0;
    case (funct3)
      3'b000:  branch_condition = (operand_1 == operand_2);
      3'b001:  branch_condition = (operand_1 != operand_2);
      3'b100:  branch_condition = ($signed(operand_1) <  $signed(operand_2));
      3'b101:  branch_condition = ($signed(operand_1) >= $signed(operand_2));
      3'b110:  branch_condition = (operand_1 <  operand_2);
      3'b111:  branch_condition = (operand_1 >= operand_2);
      default: branch_condition = 1'b0;
    endcase
  end
endmodule

// File: rtl/decoder.sv
// RV32I opcode classifier: decoded bundle, source indices and which sources are read.
module decoder
  import decode_pkg::*;
(
  input  logic [ILEN-1:0]  instruction,
  input  logic             instruction_valid,
  output decoded_t         decoded,
  output logic [REG_W-1:0] rs1,
  output logic [REG_W-1:0] rs2,
  output logic             uses_rs1,
  output logic             uses_rs2
);
  logic [ILEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u = {instruction[31:12], 12'b0};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0};
  assign rs1   = instruction[19:15];
  assign rs2   = instruction[24:20];

  always_comb begin
    decoded                = '0;
    uses_rs1               = 1'b0;
    uses_rs2               = 1'b0;
    decoded.write_register = instruction[11:7];
    decoded.funct3         = instruction[14:12];
    decoded.funct7         = instruction[31:25];
    if (instruction_valid) begin
      decoded.opcode_legal = 1'b1;
      case (instruction[6:0])
        OP_LUI, OP_AUIPC: begin
          decoded.is_alu = 1'b1; decoded.immediate = imm_u; decoded.immediate_valid = 1'b1;
          decoded.writeback = 1'b1;
        end
        OP_JAL: begin
          decoded.is_jump = 1'b1; decoded.immediate = imm_j; decoded.immediate_valid = 1'b1;
          decoded.writeback = 1'b1;
        end
        OP_JALR: begin
          decoded.is_jump = 1'b1; decoded.is_jump_register = 1'b1; decoded.immediate = imm_i;
          decoded.immediate_valid = 1'b1; decoded.writeback = 1'b1; decoded.funct3_valid = 1'b1;
          uses_rs1 = 1'b1;
        end
        OP_BRANCH: begin
          decoded.is_branch = 1'b1; decoded.immediate = imm_b; decoded.immediate_valid = 1'b1;
          decoded.funct3_valid = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        end
        OP_LOAD: begin
          decoded.is_load = 1'b1; decoded.immediate = imm_i; decoded.immediate_valid = 1'b1;
          decoded.writeback = 1'b1; decoded.funct3_valid = 1'b1; uses_rs1 = 1'b1;
        end
        OP_STORE: begin
          decoded.is_store = 1'b1; decoded.immediate = imm_s; decoded.immediate_valid = 1'b1;
          decoded.funct3_valid = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        end
        OP_IMM: begin
          decoded.is_alu = 1'b1; decoded.immediate = imm_i; decoded.immediate_valid = 1'b1;
          decoded.writeback = 1'b1; decoded.funct3_valid = 1'b1; uses_rs1 = 1'b1;
        end
        OP_REG: begin
          decoded.is_alu = 1'b1; decoded.writeback = 1'b1; decoded.funct3_valid = 1'b1;
          decoded.funct7_valid = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        end
        default: decoded.opcode_legal = 1'b0;
      endcase
    end
  end
endmodule

// File: rtl/instruction_queue.sv
// Power-of-two FIFO of fetch entries; clear wins over push and pop.
module instruction_queue
  import decode_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  queue_entry_t             entry_in,
  output queue_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  queue_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= entry_in;
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/decode_queue_stage.sv
// Decode stage: fetch queue, head decode with operand bypass, registered output slot and redirect pulse.
module decode_queue_stage
  import decode_pkg::*;
#(
  parameter int ADDR_WIDTH        = 32,
  parameter int DATA_WIDTH        = 32,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int NUM_REGISTERS     = 32,
  parameter int QUEUE_DEPTH       = 4,
  parameter int NUM_BYPASS        = 2
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           prev_done,
  output logic                                           stall_prev,
  input  logic                                           next_stall,
  output logic                                           done_next,
  input  logic [ADDR_WIDTH-1:0]                          program_count_in,
  input  logic                                           program_count_valid_in,
  input  logic [INSTRUCTION_WIDTH-1:0]                   instruction_data_in,
  input  logic                                           instruction_data_valid_in,
  output logic [$clog2(NUM_REGISTERS)-1:0]               register_read_1,
  output logic [$clog2(NUM_REGISTERS)-1:0]               register_read_2,
  input  logic [DATA_WIDTH-1:0]                          register_read_1_data,
  input  logic [DATA_WIDTH-1:0]                          register_read_2_data,
  input  logic                                           register_read_1_contended,
  input  logic                                           register_read_2_contended,
  input  logic [NUM_BYPASS-1:0]                          bypass_valid,
  input  logic [NUM_BYPASS-1:0][$clog2(NUM_REGISTERS)-1:0] bypass_register,
  input  logic [NUM_BYPASS-1:0][DATA_WIDTH-1:0]          bypass_data,
  input  logic                                           flush_in,
  output logic                                           redirect_valid,
  output logic [ADDR_WIDTH-1:0]                          redirect_target,
  output decoded_t                                       decoded_out,
  output logic [DATA_WIDTH-1:0]                          register_1_data_out,
  output logic [DATA_WIDTH-1:0]                          register_2_data_out,
  output logic [$clog2(QUEUE_DEPTH):0]                   queue_count
);
  localparam int IDX_W = $clog2(NUM_REGISTERS);
  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  queue_entry_t          head, entry_in;
  decoded_t              head_dec;
  logic [REG_W-1:0]      rs1, rs2;
  logic                  uses_rs1, uses_rs2, branch_condition;
  logic [DATA_WIDTH:0]   res1, res2;
  logic                  head_ready, load, take_flow, clear_q, out_valid;
  logic [ADDR_WIDTH-1:0] next_target;

  // Returns {stall, data}: x0 is zero, lowest-index bypass wins, then an uncontended register file.
  function automatic logic [DATA_WIDTH:0] resolve_operand(
    input logic [IDX_W-1:0]                      idx,
    input logic [DATA_WIDTH-1:0]                 rf_data,
    input logic                                  contended,
    input logic [NUM_BYPASS-1:0]                 bv,
    input logic [NUM_BYPASS-1:0][IDX_W-1:0]      br,
    input logic [NUM_BYPASS-1:0][DATA_WIDTH-1:0] bd
  );
    logic [DATA_WIDTH-1:0] value;
    logic                  hit;
    value = rf_data;
    hit   = 1'b0;
    for (int i = NUM_BYPASS - 1; i >= 0; i--) begin
      if (bv[i] && br[i] == idx) begin
        value = bd[i];
        hit   = 1'b1;
      end
    end
    if (idx == '0) return {1'b0, {DATA_WIDTH{1'b0}}};
    return {!hit && contended, value};
  endfunction

  // Handshake: an entry moves on a cycle where the producer offers it (prev_done / done_next)
  // and the consumer does not refuse it (stall_prev / next_stall) at the same clock edge.
  assign entry_in   = '{pc: program_count_in, pc_valid: program_count_valid_in,
                        instruction: instruction_data_in, instruction_valid: instruction_data_valid_in};
  assign stall_prev = !rst_n || (queue_count == CNT_W'(QUEUE_DEPTH)) || redirect_valid;
  assign done_next  = out_valid;

  instruction_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (prev_done && !stall_prev),
    .pop      (load),
    .clear    (clear_q),
    .entry_in (entry_in),
    .head     (head),
    .count    (queue_count)
  );

  decoder u_decoder (
    .instruction       (head.instruction),
    .instruction_valid (head.instruction_valid && head.pc_valid),
    .decoded           (head_dec),
    .rs1               (rs1),
    .rs2               (rs2),
    .uses_rs1          (uses_rs1),
    .uses_rs2          (uses_rs2)
  );

  branching #(.DATA_WIDTH(DATA_WIDTH)) u_branching (
    .funct3           (head_dec.funct3),
    .operand_1        (res1[DATA_WIDTH-1:0]),
    .operand_2        (res2[DATA_WIDTH-1:0]),
    .branch_condition (branch_condition)
  );

  assign register_read_1 = rs1;
  assign register_read_2 = rs2;
  assign res1 = resolve_operand(register_read_1, register_read_1_data, register_read_1_contended,
                                bypass_valid, bypass_register, bypass_data);
  assign res2 = resolve_operand(register_read_2, register_read_2_data, register_read_2_contended,
                                bypass_valid, bypass_register, bypass_data);

  assign head_ready  = (queue_count != '0) &&
                       !((uses_rs1 && res1[DATA_WIDTH]) || (uses_rs2 && res2[DATA_WIDTH]));
  assign load        = head_ready && (!out_valid || !next_stall);
  assign take_flow   = head_dec.is_jump || (head_dec.is_branch && branch_condition);
  assign clear_q     = flush_in || (load && take_flow);
  assign next_target = head_dec.is_jump_register
                     ? ((res1[ADDR_WIDTH-1:0] + head_dec.immediate[ADDR_WIDTH-1:0]) & ~ADDR_WIDTH'(1))
                     : (head.pc + head_dec.immediate[ADDR_WIDTH-1:0]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      redirect_valid <= 1'b0;
    end else begin
      redirect_valid <= 1'b0;
      if (flush_in) begin
        out_valid <= 1'b0;
      end else if (load) begin
        out_valid      <= 1'b1;
        redirect_valid <= take_flow;
      end else if (!next_stall) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      decoded_out                   <= head_dec;
      decoded_out.pc                <= head.pc;
      decoded_out.target_misaligned <= take_flow && (next_target[1:0] != 2'b00);
      register_1_data_out           <= res1[DATA_WIDTH-1:0];
      register_2_data_out           <= res2[DATA_WIDTH-1:0];
      redirect_target               <= next_target;
    end
  end
endmodule

// File: doc/decode_queue_stage.md
# decode_queue_stage

Decode stage for the in-order pipeline, replacing the single-entry decode slot with a parametrised instruction queue, a registered output slot, operand bypass from later stages, and a registered one-cycle redirect pulse for jumps and taken branches. It sits between fetch and execute and uses the `stall`/`done` handshake on both sides. It reuses the existing `decoder` and `branching` blocks to classify the instruction at the queue head and resolve its branches.

## Interface
- `ADDR_WIDTH`, default 32: program counter width.
- `DATA_WIDTH`, default 32: register data width.
- `INSTRUCTION_WIDTH`, default 32: instruction word width.
- `NUM_REGISTERS`, default 32: architectural register count; index width is `$clog2(NUM_REGISTERS)`.
- `QUEUE_DEPTH`, default 4: queue entries; must be a power of two and at least 2.
- `NUM_BYPASS`, default 2: forwarding sources; index 0 has the highest priority.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  synchronous reset, active-low.
- `prev_done`  in  1  fetch offers an entry this cycle.
- `stall_prev`  out  1  stage refuses the fetch entry this cycle.
- `next_stall`  in  1  execute refuses the output slot this cycle.
- `done_next`  out  1  output slot holds a valid instruction.
- `program_count_in`  in  ADDR_WIDTH  fetch PC.
- `program_count_valid_in`  in  1  fetch PC valid.
- `instruction_data_in`  in  INSTRUCTION_WIDTH  fetched instruction word.
- `instruction_data_valid_in`  in  1  instruction word valid.
- `register_read_1`, `register_read_2`  out  log2(NUM_REGISTERS)  register-file read indices, taken from the head entry.
- `register_read_1_data`, `register_read_2_data`  in  DATA_WIDTH  register-file read data.
- `register_read_1_contended`, `register_read_2_contended`  in  1  register has a write pending.
- `bypass_valid`  in  NUM_BYPASS  bypass source carries a result.
- `bypass_register`  in  NUM_BYPASS × log2(NUM_REGISTERS)  destination register of each source.
- `bypass_data`  in  NUM_BYPASS × DATA_WIDTH  result data of each source.
- `flush_in`  in  1  later stage discards all younger work.
- `redirect_valid`  out  1  one-cycle pulse: fetch must restart.
- `redirect_target`  out  ADDR_WIDTH  restart address.
- `decoded_out`  out  `decoded_t`  registered decode bundle.
- `register_1_data_out`, `register_2_data_out`  out  DATA_WIDTH  resolved operands.
- `queue_count`  out  log2(QUEUE_DEPTH)+1  current queue occupancy.

## Operation
- **Push.** A fetch entry is accepted when `prev_done && !stall_prev`. Each entry is {pc, pc_valid, instruction, instruction_valid}.
- **Stall to fetch.** `stall_prev` = `!rst_n || count==QUEUE_DEPTH || redirect_valid`. No push is allowed when the queue is full, even if a pop happens in the same cycle.
- **Head decode.** The head entry is decoded combinationally.
- **Operand resolution**, per source register the head actually uses:
  - Index 0 reads zero and never stalls.
  - Otherwise, the lowest-index bypass with `bypass_valid` and a matching `bypass_register` supplies the data.
  - Otherwise, the register file supplies the data if the register is not contended.
  - Otherwise, the head is operand-stalled.
- **Head ready** = queue not empty && no operand stall.
- **Output load.** The output slot loads when head ready && (`!out_valid || !next_stall`). Loading pops the queue. If the slot empties and the head is not ready, `out_valid` clears.
- **Control flow.** When the loaded head is a jump, or a branch with `branch_condition`=1:
  - next cycle, `redirect_valid`=1 and `redirect_target` = pc+imm (branch, immediate jump) or (rs1+imm)&~1 (register jump);
  - at the same edge, the remaining queue is cleared and any same-cycle push is dropped.
- **Misaligned target.** If `redirect_target[1:0]`≠0, the redirect still issues and `decoded_out.target_misaligned`=1.
- **Not-taken branch or illegal opcode.** No redirect; `opcode_legal`=0 passes through in `decoded_out`.
- **Flush.** `flush_in` clears the queue and the output slot and cancels a pending redirect at the next edge. It takes priority over push, pop and redirect.
- **Reset.** While `rst_n`=0: count=0, `out_valid`=0, `redirect_valid`=0, `done_next`=0, `stall_prev`=1. Pointers reset to 0. Data registers are not reset.
- **Arithmetic.** Pointers wrap modulo QUEUE_DEPTH. Target sums truncate to ADDR_WIDTH.

## Timing
- **Latency.** With the queue and slot empty, a push at edge N gives `done_next`=1 after edge N+1.
- **Throughput.** One instruction per cycle when no operand stall and no redirect occur.
- **Handshake.** `done_next` = `out_valid`. Outputs stay stable while `next_stall`=1.
- **Redirect pulse.** Lasts exactly one cycle and blocks pushes during that cycle.
- **Bypass.** Sampled combinationally in the cycle the head loads. No bypass is captured for queued entries.

## Structure
- Package `decode_pkg` holds:
  - the `decoded_t` struct: instruction class flags, `opcode_legal`, immediate and valid bit, write register and writeback enable, funct3/funct7 and their valid bits, pc, `target_misaligned`;
  - the `queue_entry_t` struct.
- Sub-module `instruction_queue` is a parametrised FIFO with push, pop and clear, exposing count and head.
- The existing `decoder` and `branching` blocks are instantiated unchanged.

## Test plan
- Push 4 ALU ops back-to-back with `next_stall`=0 → `done_next` rises 2 cycles after the first push; 4 consecutive outputs in order; `queue_count` peaks at 1.
- Hold `next_stall`=1 and push 6 entries (depth 4) → `queue_count` reaches 4 then 4+slot; `stall_prev`=1; entries 6+ are not accepted; release → order preserved.
- Head reads x5 contended; `bypass_valid`=2'b11 with both sources targeting x5, data 0xAA/0xBB → `register_1_data_out`=0xAA, no stall; repeat without bypass → stall until contention drops.
- JAL at pc 0x100 with imm 0x40, followed by 2 queued entries → `redirect_valid` pulse with target 0x140; queue empties; next output is the post-redirect fetch.
- `flush_in` with 3 queued entries and a valid slot → next cycle count=0, `done_next`=0, no redirect.
- Drive `rst_n`=0 mid-stream for 1 cycle → all valids 0, `stall_prev`=1 during reset; normal operation on the next push.
